// File: rtl/zprize_div_98_if.sv
// Operand/result handshake bundle for the restoring divider.
// Master drives operands and accepts results; slave is the divider.
interface zprize_div_98_if #(
  parameter int W = 384,
  parameter int M = 32
);
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] num;
  logic [W-1:0]   den;
  logic [M-1:0]   m_i;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] quo;
  logic [W-1:0]   rem;
  logic           dz;
  logic [M-1:0]   m_o;

  modport master (
    output in_valid, num, den, m_i, out_ready,
    input  in_ready, out_valid, quo, rem, dz, m_o
  );

  modport slave (
    input  in_valid, num, den, m_i, out_ready,
    output in_ready, out_valid, quo, rem, dz, m_o
  );
endinterface

// File: rtl/zprize_div_98.sv
// Sequential restoring divider (2W / W), RB quotient bits per cycle, one operation in flight.
// Latency N+1 edges (1 for divide-by-zero); result held in DONE until out_ready.
module zprize_div_98 #(
  parameter int W  = 384,
  parameter int RB = 1,
  parameter int M  = 32
) (
  input  logic               clk,
  input  logic               rst,
  zprize_div_98_if.slave     io
);
  localparam int N  = 2 * W / RB;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nx;
  logic [2*W-1:0] sr, sr_nx;
  logic [W-1:0]   p, p_nx;
  logic [W:0]     pt;
  logic [W-1:0]   d_r;
  logic [M-1:0]   m_r;
  logic [CW-1:0]  cnt;
  logic           dz_r;
  logic           last;

  assign last = (cnt == CW'(N - 1));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (io.in_valid) state_nx = (io.den == '0) ? DONE : RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    if (io.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // RB restoring steps chained per cycle; the stored remainder is always < d_r,
  // so only the shifted trial value needs the extra bit.
  always_comb begin
    p_nx  = p;
    sr_nx = sr;
    pt    = '0;
    for (int i = 0; i < RB; i++) begin
      pt    = {p_nx, sr_nx[2*W-1]};
      sr_nx = {sr_nx[2*W-2:0], 1'b0};
      if (pt >= {1'b0, d_r}) begin
        pt       = pt - {1'b0, d_r};
        sr_nx[0] = 1'b1;
      end
      p_nx = pt[W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sr    <= '0;
      p     <= '0;
      d_r   <= '0;
      m_r   <= '0;
      cnt   <= '0;
      dz_r  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && io.in_valid) begin
        d_r <= io.den;
        m_r <= io.m_i;
        cnt <= '0;
        if (io.den == '0) begin
          sr   <= '1;
          p    <= io.num[W-1:0];
          dz_r <= 1'b1;
        end else begin
          sr   <= io.num;
          p    <= '0;
          dz_r <= 1'b0;
        end
      end else if (state == RUN) begin
        sr  <= sr_nx;
        p   <= p_nx;
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign io.in_ready  = (state == IDLE);
  assign io.out_valid = (state == DONE);
  assign io.quo       = sr;
  assign io.rem       = p;
  assign io.dz        = dz_r;
  assign io.m_o       = m_r;
endmodule

// File: tb/tb_zprize_div_98.sv
// Directed bench: two W=8 dividers (RB=1 and RB=2) share one operand stream.
module tb_zprize_div_98;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready;
  logic [15:0] num;
  logic [7:0]  den;
  logic [31:0] m_i;

  int checks = 0;
  int errors = 0;
  int e, lat1, lat2, acc1, acc2;
  logic got1, got2;
  logic [15:0] exp_q;
  logic [7:0]  exp_r;

  always #5 clk = ~clk;

  zprize_div_98_if #(.W(8), .M(32)) io1 ();
  zprize_div_98_if #(.W(8), .M(32)) io2 ();

  assign io1.in_valid  = in_valid;
  assign io1.num       = num;
  assign io1.den       = den;
  assign io1.m_i       = m_i;
  assign io1.out_ready = out_ready;
  assign io2.in_valid  = in_valid;
  assign io2.num       = num;
  assign io2.den       = den;
  assign io2.m_i       = m_i;
  assign io2.out_ready = out_ready;

  zprize_div_98 #(.W(8), .RB(1), .M(32)) dut1 (.clk(clk), .rst(rst), .io(io1));
  zprize_div_98 #(.W(8), .RB(2), .M(32)) dut2 (.clk(clk), .rst(rst), .io(io2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_accept();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    e = 1;
  endtask

  task automatic wait_done();
    lat1 = 0;
    lat2 = 0;
    repeat (40) begin
      if (lat1 == 0 && io1.out_valid) lat1 = e;
      if (lat2 == 0 && io2.out_valid) lat2 = e;
      if (lat1 != 0 && lat2 != 0) break;
      step();
      e++;
    end
  endtask

  task automatic check_both(input string tag, input logic [15:0] q, input logic [7:0] r,
                            input logic z, input logic [31:0] t);
    chk({tag, "_quo1"}, 32'(io1.quo), 32'(q));
    chk({tag, "_rem1"}, 32'(io1.rem), 32'(r));
    chk({tag, "_dz1"},  32'(io1.dz),  32'(z));
    chk({tag, "_mo1"},  io1.m_o,      t);
    chk({tag, "_quo2"}, 32'(io2.quo), 32'(q));
    chk({tag, "_rem2"}, 32'(io2.rem), 32'(r));
    chk({tag, "_dz2"},  32'(io2.dz),  32'(z));
    chk({tag, "_mo2"},  io2.m_o,      t);
  endtask

  task automatic release_both();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    num = '0; den = '0; m_i = '0;
    step(); step();
    chk("rst_in_ready1", 32'(io1.in_ready), 32'd1);
    chk("rst_in_ready2", 32'(io2.in_ready), 32'd1);
    chk("rst_out_valid1", 32'(io1.out_valid), 32'd0);
    chk("rst_out_valid2", 32'(io2.out_valid), 32'd0);
    check_both("rst", 16'h0000, 8'h00, 1'b0, 32'h0);
    rst = 1'b1;
    step();

    // 0x1234 / 0x56, with an ignored in_valid pulse while busy
    num = 16'h1234; den = 8'h56; m_i = 32'hA5A5_0001;
    do_accept();
    num = 16'hFFFF; den = 8'h01; m_i = 32'hDEAD_BEEF; in_valid = 1'b1;
    step(); e++;
    step(); e++;
    in_valid = 1'b0;
    wait_done();
    chk("lat_rb1", lat1, 32'd17);
    chk("lat_rb2", lat2, 32'd9);
    check_both("div1234", 16'h0036, 8'h10, 1'b0, 32'hA5A5_0001);

    // Backpressure: held in DONE with a queued operand
    num = 16'hFFFE; den = 8'hFF; m_i = 32'h0000_0002; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_quo1", 32'(io1.quo), 32'h0036);
      chk("bp_rem2", 32'(io2.rem), 32'h10);
      chk("bp_in_ready1", 32'(io1.in_ready), 32'd0);
      chk("bp_out_valid2", 32'(io2.out_valid), 32'd1);
    end
    out_ready = 1'b1;
    step();
    chk("bp_idle_in_ready1", 32'(io1.in_ready), 32'd1);
    chk("bp_idle_in_ready2", 32'(io2.in_ready), 32'd1);
    chk("bp_idle_out_valid1", 32'(io1.out_valid), 32'd0);
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    e = 1;
    chk("bp_accepted1", 32'(io1.in_ready), 32'd0);
    chk("bp_accepted2", 32'(io2.in_ready), 32'd0);
    wait_done();
    chk("lat2_rb1", lat1, 32'd17);
    chk("lat2_rb2", lat2, 32'd9);
    check_both("divFFFE", 16'h0100, 8'hFE, 1'b0, 32'h0000_0002);
    release_both();

    num = 16'hFFFF; den = 8'h01; m_i = 32'h1234_5678;
    do_accept();
    wait_done();
    check_both("divFFFF", 16'hFFFF, 8'h00, 1'b0, 32'h1234_5678);
    release_both();

    // Divide by zero
    num = 16'h1234; den = 8'h00; m_i = 32'hCAFE_0000;
    do_accept();
    wait_done();
    chk("lat_dz1", lat1, 32'd1);
    chk("lat_dz2", lat2, 32'd1);
    check_both("dz", 16'hFFFF, 8'h34, 1'b1, 32'hCAFE_0000);
    release_both();

    // Throughput with out_ready tied high
    out_ready = 1'b1; in_valid = 1'b1;
    acc1 = 0; acc2 = 0;
    for (int i = 0; i < 20; i++) begin
      acc1 += int'(io1.in_ready);
      acc2 += int'(io2.in_ready);
      step();
    end
    chk("tp_dz1", acc1, 32'd10);
    chk("tp_dz2", acc2, 32'd10);
    num = 16'h0F00; den = 8'h33;
    acc1 = 0; acc2 = 0;
    for (int i = 0; i < 60; i++) begin
      acc1 += int'(io1.in_ready);
      acc2 += int'(io2.in_ready);
      step();
    end
    chk("tp_rb1", acc1, 32'd4);
    chk("tp_rb2", acc2, 32'd6);
    in_valid = 1'b0;
    repeat (20) step();
    out_ready = 1'b0;

    // Reset during RUN
    num = 16'h1234; den = 8'h56; m_i = 32'h7777_7777;
    do_accept();
    repeat (4) step();
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid1", 32'(io1.out_valid), 32'd0);
    chk("mid_rst_out_valid2", 32'(io2.out_valid), 32'd0);
    check_both("mid_rst", 16'h0000, 8'h00, 1'b0, 32'h0);
    step();
    rst = 1'b1;
    step();
    chk("post_rst_in_ready1", 32'(io1.in_ready), 32'd1);
    chk("post_rst_in_ready2", 32'(io2.in_ready), 32'd1);
    num = 16'h0064; den = 8'h07; m_i = 32'h0000_0064;
    do_accept();
    wait_done();
    chk("lat3_rb1", lat1, 32'd17);
    check_both("div64", 16'h000E, 8'h02, 1'b0, 32'h0000_0064);
    release_both();

    // Random vectors with random gaps and out_ready
    for (int v = 0; v < 24; v++) begin
      num = 16'($urandom);
      den = 8'($urandom_range(0, 255));
      m_i = $urandom;
      exp_q = (den != 0) ? num / 16'(den) : 16'hFFFF;
      exp_r = (den != 0) ? 8'(num % 16'(den)) : num[7:0];
      repeat ($urandom_range(0, 3)) step();
      do_accept();
      got1 = 1'b0; got2 = 1'b0;
      for (int c = 0; c < 200 && !(got1 && got2); c++) begin
        out_ready = 1'($urandom_range(0, 1));
        if (!got1 && io1.out_valid && out_ready) begin
          chk("rnd_quo1", 32'(io1.quo), 32'(exp_q));
          chk("rnd_rem1", 32'(io1.rem), 32'(exp_r));
          chk("rnd_mo1", io1.m_o, m_i);
          got1 = 1'b1;
        end
        if (!got2 && io2.out_valid && out_ready) begin
          chk("rnd_quo2", 32'(io2.quo), 32'(exp_q));
          chk("rnd_rem2", 32'(io2.rem), 32'(exp_r));
          chk("rnd_mo2", io2.m_o, m_i);
          got2 = 1'b1;
        end
        step();
      end
      chk("rnd_done", 32'({got1, got2}), 32'd3);
      out_ready = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/zprize_div_98.md
# zprize_div_98

Sequential restoring divider that runs the inverse operation of the `zprize_mul_98` Karatsuba multiplier. It takes a 2W-bit product-width numerator and a W-bit divisor and returns a 2W-bit quotient and a W-bit remainder, with an M-bit sideband tag carried through. It sits on the verification and reduction side of the MSM datapath: it recovers factors from multiplier outputs and reduces wide products by non-constant moduli. It uses valid/ready handshakes on both ends and processes one operation at a time, retiring RB quotient bits per cycle.

## Interface
- W, 384, divisor and remainder width; numerator and quotient are 2W.
- RB, 1, quotient bits retired per cycle; must divide 2W; legal values 1, 2, 4.
- M, 32, sideband tag width.
- N (derived), 2W/RB, number of iteration cycles.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept an operand.
- num  in  2W  numerator.
- den  in  W  divisor.
- m_i  in  M  sideband tag.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- quo  out  2W  quotient.
- rem  out  W  remainder.
- dz  out  1  divide-by-zero flag.
- m_o  out  M  tag captured with the operand.

## Operation
- FSM states are IDLE, RUN and DONE. The reset state is IDLE.
- in_ready = (state==IDLE). out_valid = (state==DONE).
- Accept (IDLE, in_valid=1):
  - Latch num into a shift register, den into d_r, and m_i into m_r.
  - Clear the partial remainder p (W+1 bits) and the iteration counter.
  - If den==0, go to DONE and set quo = all ones, rem = num[W-1:0], dz = 1.
  - Otherwise go to RUN and set dz = 0.
- RUN, per cycle, RB sub-steps chained combinationally, MSB first. Each sub-step:
  - p' = {p[W-1:0], next numerator bit}.
  - If p' >= d_r, then p = p' - d_r and the quotient bit is 1.
  - Otherwise p = p' and the quotient bit is 0.
  - Shift the quotient bits into the low end of the quotient register, which reuses the numerator shift register.
  - p never exceeds W+1 bits. Comparison and subtraction are unsigned, W+1 bits wide.
- The counter increments once per RUN cycle. When the counter reaches N-1, the next edge enters DONE.
- In DONE:
  - quo = the quotient register, rem = p[W-1:0], m_o = m_r.
  - Hold all outputs stable while out_ready=0.
- A DONE cycle with out_ready=1 returns to IDLE on the next edge. in_ready is not asserted in the same cycle; there is no bypass.
- m_o is returned unchanged, bit-exact, for every operation, including divide-by-zero.
- Operands are unsigned. num < den gives quo = 0 and rem = num[W-1:0].

## Timing
- Reset (rst=0, any state, including mid-RUN): asynchronously forces IDLE. in_ready=1 once rst deasserts. out_valid, quo, rem, dz and m_o all read 0. The in-flight operation is discarded with no output.
- Latency, from the accept edge to the first cycle with out_valid=1:
  - den≠0: N+1 edges, i.e. accept edge, N RUN edges, then DONE.
  - den==0: 1 edge.
- Throughput, with out_ready tied high:
  - One result per N+2 cycles.
  - Divide-by-zero streams: one per 2 cycles.
- in_valid while in_ready=0 has no effect. Upstream must hold the operand until in_ready.
- quo, rem, dz and m_o are registered outputs and have no combinational path from the inputs.
- out_ready stuck at 0 stalls the block in DONE indefinitely. The result is held and no new operand is accepted.

## Test plan
- W=8, RB=1: num=0x1234, den=0x56 -> after 17 edges, quo=0x0036, rem=0x10, dz=0, m_o=m_i.
- W=8, RB=2: num=0xFFFE, den=0xFF -> after 9 edges, quo=0x0100, rem=0xFE. Repeat with num=0xFFFF, den=0x01 -> quo=0xFFFF, rem=0x00.
- W=8: num=0x1234, den=0x00 -> after 1 edge, out_valid=1, quo=0xFFFF, rem=0x34, dz=1.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0.
  - Raise out_ready -> next cycle IDLE, in_ready=1.
  - The queued in_valid is accepted on the following edge.
- Reset mid-RUN: deassert rst at iteration 5 -> state IDLE, out_valid=0, all outputs 0. A fresh 0x0064/0x07 after release -> quo=0x000E, rem=0x02.
- Random regression, W=384 and W=16, all RB values, random out_ready and in_valid gaps -> quo*den + rem == num and rem < den for every den≠0; tags in order; compare against a golden model.
